ws2812_frame_driver: RTL and testbench

- Downstream neighbour of the display unit.
- Walks the LED index `current_led` over the strip and samples the combinational G/R/B intensities returned for that index.
- Serialises each pixel onto a single WS2812 data line, then emits the latch/reset gap.
- Starts a frame on `update_frame`; a request that arrives mid-frame is queued.

---
 rtl/ws2812_frame_driver.sv | 131 +++++++++++++
 tb/tb_ws2812_frame_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_driver.sv
// ============================================================================
//  Module      : ws2812_frame_driver
//  Description : Walks an LED strip, samples G/R/B per index and serialises the
//                frame onto a WS2812 line followed by the latch gap. Optional
//                output dimming is enabled with the WS2812_DIM_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_frame_driver #(
  parameter int MAX_POS      = 16,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 63,
  parameter int RESET_CYCLES = 2600
`ifdef WS2812_DIM_EN
  , parameter int DIM_SHIFT  = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 update_frame,
  input  logic [7:0]           led_green_intensity,
  input  logic [7:0]           led_red_intensity,
  input  logic [7:0]           led_blue_intensity,
  output logic [((MAX_POS > 1) ? $clog2(MAX_POS) : 1)-1:0] current_led,
  output logic                 data_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int LED_W   = (MAX_POS > 1) ? $clog2(MAX_POS) : 1;
  localparam int CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [LED_W-1:0] LAST_LED = LED_W'(MAX_POS - 1);
  localparam logic [LED_W-1:0] LED_ONE  = (MAX_POS == 1) ? '0 : LED_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]       state;
  logic [23:0]      shift;
  logic [LED_W-1:0] pix_cnt;
  logic [4:0]       bit_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             pending;
  logic [23:0]      pixel;

  always_comb begin
`ifdef WS2812_DIM_EN
    pixel = {led_green_intensity >> DIM_SHIFT,
             led_red_intensity   >> DIM_SHIFT,
             led_blue_intensity  >> DIM_SHIFT};
`else
    pixel = {led_green_intensity, led_red_intensity, led_blue_intensity};
`endif
  end

  // Outputs decode straight from registers so an async reset silences the line at once.
  assign data_out   = (state == S_SEND) && (cyc_cnt < (shift[23] ? T1H_C : T0H_C));
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_LATCH) && (cyc_cnt == RST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      current_led <= '0;
      shift       <= '0;
      pix_cnt     <= '0;
      bit_cnt     <= '0;
      cyc_cnt     <= '0;
      pending     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          current_led <= '0;
          if (update_frame || pending) state <= S_LOAD;
        end
        S_LOAD: begin
          shift       <= pixel;
          pix_cnt     <= '0;
          bit_cnt     <= '0;
          cyc_cnt     <= '0;
          pending     <= 1'b0;
          current_led <= LED_ONE;
          state       <= S_SEND;
        end
        S_SEND: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt != 5'd23) begin
              shift   <= {shift[22:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end else if (pix_cnt != LAST_LED) begin
              shift       <= pixel;
              pix_cnt     <= pix_cnt + 1'b1;
              bit_cnt     <= '0;
              current_led <= (current_led == LAST_LED) ? '0 : current_led + 1'b1;
            end else begin
              state       <= S_LATCH;
              current_led <= '0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (cyc_cnt == RST_LAST) begin
            cyc_cnt <= '0;
            state   <= (pending || update_frame) ? S_LOAD : S_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so a request landing in the LOAD cycle is still queued.
      if (update_frame && (state != S_IDLE)) pending <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_driver.sv
// Scoreboard bench: stimulus queues expected bits/frame lengths, one monitor decodes the lines.
`default_nettype none

module tb_ws2812_frame_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic upd0, upd1;
  logic d0, b0, f0, d1, b1, f1;
  logic [0:0] l0, l1;
  logic [23:0] tab0 [2];
  logic [23:0] tab1;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  bit fin = 1'b0;

  bit eb0[$], eb1[$];
  int el0[$], el1[$];
  bit enb0[$], enb1[$];

  always #5 clk = ~clk;

  ws2812_frame_driver #(.MAX_POS(2), .T0H_CYCLES(2), .T1H_CYCLES(4), .BIT_CYCLES(6),
                        .RESET_CYCLES(10)
`ifdef WS2812_DIM_EN
    , .DIM_SHIFT(2)
`endif
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .update_frame(upd0),
    .led_green_intensity(tab0[l0][23:16]), .led_red_intensity(tab0[l0][15:8]),
    .led_blue_intensity(tab0[l0][7:0]),
    .current_led(l0), .data_out(d0), .busy(b0), .frame_done(f0)
  );

  ws2812_frame_driver #(.MAX_POS(1), .T0H_CYCLES(2), .T1H_CYCLES(4), .BIT_CYCLES(6),
                        .RESET_CYCLES(10)
`ifdef WS2812_DIM_EN
    , .DIM_SHIFT(2)
`endif
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .update_frame(upd1),
    .led_green_intensity(tab1[23:16]), .led_red_intensity(tab1[15:8]),
    .led_blue_intensity(tab1[7:0]),
    .current_led(l1), .data_out(d1), .busy(b1), .frame_done(f1)
  );

  function automatic logic [23:0] dimp(input logic [23:0] p);
`ifdef WS2812_DIM_EN
    return {p[23:16] >> 2, p[15:8] >> 2, p[7:0] >> 2};
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int  cyc = 0;
  int  h[2], last_rise[2], fstart[2];
  logic prev_d[2], prev_b[2], prev_f[2];
  bit  chk_next[2], exp_nb[2];

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      h[i] = 0; last_rise[i] = -1; fstart[i] = 0;
      prev_d[i] = 1'b0; prev_b[i] = 1'b0; prev_f[i] = 1'b0;
      chk_next[i] = 1'b0; exp_nb[i] = 1'b0;
    end
  endtask

  task automatic mon_dut(input int i, input logic d, input logic b, input logic f,
                         input logic l);
    int off, sz, len;
    bit eb, nb;
    if (chk_next[i]) begin
      check($sformatf("busy after frame_done dut%0d", i), int'(b), int'(exp_nb[i]));
      chk_next[i] = 1'b0;
    end
    if (b && (!prev_b[i] || prev_f[i])) begin
      fstart[i] = cyc;
      last_rise[i] = -1;
      sz = (i == 0) ? el0.size() : el1.size();
      check($sformatf("frame start expected dut%0d", i), int'(sz > 0), 1);
    end
    if (b) begin
      off = cyc - fstart[i];
      if (i == 0 && (off == 0 || off == 145 || off == 290))
        check($sformatf("current_led dut0 off%0d", off), int'(l), 0);
      if (i == 0 && (off == 1 || off == 144))
        check($sformatf("current_led dut0 off%0d", off), int'(l), 1);
      if (i == 1 && (off == 1 || off == 100 || off == 150))
        check($sformatf("current_led dut1 off%0d", off), int'(l), 0);
    end
    if (d && !prev_d[i]) begin
      if (last_rise[i] >= 0)
        check($sformatf("bit period dut%0d", i), cyc - last_rise[i], 6);
      last_rise[i] = cyc;
      h[i] = 1;
    end else if (d) begin
      h[i]++;
    end else if (prev_d[i]) begin
      sz = (i == 0) ? eb0.size() : eb1.size();
      check($sformatf("bit expected dut%0d", i), int'(sz > 0), 1);
      if (sz > 0) begin
        if (i == 0) eb = eb0.pop_front(); else eb = eb1.pop_front();
        check($sformatf("high time dut%0d", i), h[i], eb ? 4 : 2);
      end
    end
    if (f) begin
      sz = (i == 0) ? el0.size() : el1.size();
      check($sformatf("frame_done expected dut%0d", i), int'(sz > 0), 1);
      if (sz > 0) begin
        if (i == 0) begin len = el0.pop_front(); nb = enb0.pop_front(); end
        else        begin len = el1.pop_front(); nb = enb1.pop_front(); end
        check($sformatf("frame length dut%0d", i), cyc - fstart[i] + 1, len);
        exp_nb[i] = nb;
        chk_next[i] = 1'b1;
      end
      last_rise[i] = -1;
    end
    prev_d[i] = d; prev_b[i] = b; prev_f[i] = f;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk) begin
        // reset asserted while clock is high: outputs must drop immediately
        #1;
        check("reset data_out dut0", int'(d0), 0);
        check("reset busy dut0", int'(b0), 0);
        check("reset current_led dut0", int'(l0), 0);
        check("reset frame_done dut0", int'(f0), 0);
        check("reset data_out dut1", int'(d1), 0);
        check("reset busy dut1", int'(b1), 0);
        eb0.delete(); el0.delete(); enb0.delete();
        eb1.delete(); el1.delete(); enb1.delete();
        clear_mon();
      end else begin
        cyc++;
        if (rst_n) begin
          mon_dut(0, d0, b0, f0, l0);
          mon_dut(1, d1, b1, f1, l1);
        end
        if (done && !fin) begin
          check("leftover bits dut0", eb0.size(), 0);
          check("leftover frames dut0", el0.size(), 0);
          check("leftover bits dut1", eb1.size(), 0);
          check("leftover frames dut1", el1.size(), 0);
          fin = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_frame0(input bit nb);
    logic [23:0] p;
    for (int k = 0; k < 2; k++) begin
      p = dimp(tab0[k]);
      for (int j = 23; j >= 0; j--) eb0.push_back(p[j]);
    end
    el0.push_back(299);
    enb0.push_back(nb);
  endtask

  task automatic pulse0();
    upd0 = 1'b1;
    @(negedge clk);
    upd0 = 1'b0;
  endtask

  initial begin
    logic [23:0] p;
    upd0 = 1'b0; upd1 = 1'b0;
    tab0[0] = 24'h0; tab0[1] = 24'h0; tab1 = 24'h0;
    #7 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single frame: A5 00 FF / 01 01 01
    tab0[0] = 24'hA500FF; tab0[1] = 24'h010101;
    push_frame0(1'b0);
    pulse0();
    repeat (310) @(negedge clk);

    // three requests mid-frame collapse into one extra frame
    tab0[0] = 24'h3CC381; tab0[1] = 24'h80007E;
    push_frame0(1'b1);
    pulse0();
    repeat (50) @(negedge clk);
    push_frame0(1'b0);
    pulse0();
    repeat (50) @(negedge clk);
    pulse0();
    repeat (100) @(negedge clk);
    pulse0();
    repeat (500) @(negedge clk);

    // reset while the first bit (a '1') is high
    tab0[0] = 24'hA500FF;
    push_frame0(1'b0);
    pulse0();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // single-LED strip; G=FF R=03 also exercises dimming when enabled
    tab1 = 24'hFF035A;
    p = dimp(tab1);
    for (int j = 23; j >= 0; j--) eb1.push_back(p[j]);
    el1.push_back(155);
    enb1.push_back(1'b0);
    upd1 = 1'b1;
    @(negedge clk);
    upd1 = 1'b0;
    repeat (180) @(negedge clk);

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
